dmem_store_buffer: RTL and testbench

- Load/store unit between the single-cycle core's execute-stage memory interface and a data memory that uses a req/ready handshake.
- Stores are posted into a FIFO write buffer and drained to memory in the background.
- Loads stall the core until their data is available. A load that matches a buffered store is served from the buffer without a memory access.
- Misaligned accesses are reported through sticky error bits.

---
 rtl/dmem_store_buffer.sv | 155 +++++++++++++++
 tb/tb_dmem_store_buffer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_store_buffer.sv
// Load/store unit: posts aligned stores into a FIFO write buffer drained to a req/ready memory,
// stalls loads until data returns, and forwards load data from the youngest matching buffered store.
module dmem_store_buffer #(
    parameter int unsigned WB_DEPTH = 4,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_read,
    input  logic              core_write,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_rvalid,
    output logic              core_stall,
    output logic [1:0]        err_bits,
    output logic              drained,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int unsigned PtrW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StStBusy, StLdBusy, StLdResp} state_e;

    state_e            state;
    logic [ADDR_W-1:0] wb_addr [WB_DEPTH];
    logic [DATA_W-1:0] wb_data [WB_DEPTH];
    logic [PtrW-1:0]   head;
    logic [PtrW-1:0]   tail;
    logic [CntW-1:0]   count;

    logic              misaligned;
    logic              wr_only;
    logic              full;
    logic              push;
    logic              pop;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [PtrW-1:0]   fwd_idx;

    // A simultaneous read wins; the write is silently dropped.
    assign misaligned = core_addr[1:0] != 2'b00;
    assign wr_only    = core_write & ~core_read;
    assign full       = count == CntW'(WB_DEPTH);
    assign push       = wr_only & ~misaligned & ~full;
    assign pop        = (state == StStBusy) & mem_req & mem_ready;
    // Full uses the registered count, so a retiring head does not unblock the store this cycle.
    assign core_stall = (core_read & ~core_rvalid) | (wr_only & ~misaligned & full);
    assign drained    = (count == '0) && (state == StIdle);

    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int i = 0; i < int'(WB_DEPTH); i++) begin
            fwd_idx = head + PtrW'(i);
            if (CntW'(i) < count && wb_addr[fwd_idx] == core_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = wb_data[fwd_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            wb_addr[tail] <= core_addr;
            wb_data[tail] <= core_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            core_rvalid <= 1'b0;
            core_rdata  <= '0;
            err_bits    <= 2'b00;
        end else begin
            core_rvalid <= 1'b0;
            if (wr_only && misaligned) err_bits[1] <= 1'b1;
            case (state)
                StIdle: begin
                    if (core_read) begin
                        if (misaligned) begin
                            err_bits[0] <= 1'b1;
                            core_rdata  <= '0;
                            core_rvalid <= 1'b1;
                            state       <= StLdResp;
                        end else if (fwd_hit) begin
                            core_rdata  <= fwd_data;
                            core_rvalid <= 1'b1;
                            state       <= StLdResp;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_addr  <= core_addr;
                            mem_wdata <= '0;
                            state     <= StLdBusy;
                        end
                    end else if (count != '0) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= wb_addr[head];
                        mem_wdata <= wb_data[head];
                        state     <= StStBusy;
                    end
                end
                StStBusy: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        state   <= StIdle;
                    end
                end
                StLdBusy: begin
                    if (mem_ready) begin
                        mem_req     <= 1'b0;
                        core_rdata  <= mem_rdata;
                        core_rvalid <= 1'b1;
                        state       <= StLdResp;
                    end
                end
                StLdResp: state <= StIdle;
                default:  state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Bench for dmem_store_buffer: directed scenarios plus random traffic, checked against an
// architectural memory model (program-order store values) and an expected write-order queue.
module tb_dmem_store_buffer;

    localparam int unsigned WB_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_read = 1'b0;
    logic        core_write = 1'b0;
    logic [31:0] core_addr = '0;
    logic [31:0] core_wdata = '0;
    logic [31:0] core_rdata;
    logic        core_rvalid;
    logic        core_stall;
    logic [1:0]  err_bits;
    logic        drained;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    dmem_store_buffer #(.WB_DEPTH(WB_DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .core_read(core_read), .core_write(core_write), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_rvalid(core_rvalid),
        .core_stall(core_stall), .err_bits(err_bits), .drained(drained),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: architectural memory (latest store in program order) and physical memory.
    logic [31:0] ref_mem  [logic [31:0]];
    logic [31:0] phys_mem [logic [31:0]];
    logic [63:0] wq [$];
    int          pushes = 0;
    int          wr_done = 0;
    int          rd_cnt = 0;
    int          rd_age = 0;
    logic [1:0]  err_m = 2'b00;

    // Memory responder: 0 never ready, 1 always, 2 random, 3 ready after rdy_delay req cycles.
    int          rdy_mode = 1;
    int          rdy_delay = 0;
    int          age = 0;
    bit          comp_pend = 0;
    bit          c_we = 0;
    logic [31:0] c_addr = '0;
    logic [31:0] c_data = '0;
    int          c_age = 0;
    bit          prev_hold = 0;
    bit          prev_done = 0;
    logic [65:0] h_req = '0;
    bit          rdy;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a ^ 32'hA5A5_0000 ^ {a[7:0], 24'h000000};
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] phys_rd(input logic [31:0] a);
        return phys_mem.exists(a) ? phys_mem[a] : init_val(a);
    endfunction

    function automatic int occ();
        return pushes - wr_done;
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            age       = 0;
            prev_hold = 0;
            prev_done = 0;
            mem_ready = 1'b0;
        end else begin
            if (prev_hold) chk("mem req held stable", {mem_req, mem_we, mem_addr, mem_wdata}, h_req);
            if (prev_done) chk("mem req drops after completion", mem_req, 1'b0);
            rdy = 1'b0;
            if (mem_req) begin
                age++;
                case (rdy_mode)
                    1:       rdy = 1'b1;
                    2:       rdy = 1'($urandom_range(0, 1));
                    3:       rdy = age > rdy_delay;
                    default: rdy = 1'b0;
                endcase
            end else if (rdy_mode == 2) begin
                rdy = 1'($urandom_range(0, 1));
            end
            mem_ready = rdy;
            mem_rdata = (mem_req && rdy && !mem_we) ? phys_rd(mem_addr) : $urandom();
            prev_hold = mem_req && !rdy;
            prev_done = mem_req && rdy;
            h_req     = {1'b1, mem_we, mem_addr, mem_wdata};
            if (mem_req && rdy) begin
                comp_pend = 1;
                c_we      = mem_we;
                c_addr    = mem_addr;
                c_data    = mem_wdata;
                c_age     = age;
                age       = 0;
            end
        end
    end

    // Completion bookkeeping uses only values captured on the preceding falling edge.
    always @(posedge clk) begin
        if (comp_pend) begin
            comp_pend = 0;
            if (c_we) begin
                wr_done++;
                chk("write expected", 32'(wq.size() != 0), 1);
                if (wq.size() != 0) chk("write order", {c_addr, c_data}, wq.pop_front());
                phys_mem[c_addr] = c_data;
            end else begin
                rd_cnt++;
                rd_age = c_age;
            end
        end
    end

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input string tag,
                            output int n);
        bit acc;
        bit exp_st;
        acc = 0;
        n = 0;
        core_read = 1'b0;
        core_write = 1'b1;
        core_addr = a;
        core_wdata = d;
        while (!acc && n < 200) begin
            @(negedge clk); #1;
            exp_st = (a[1:0] == 2'b00) && (occ() == int'(WB_DEPTH));
            chk({tag, " stall"}, core_stall, exp_st);
            acc = !exp_st;
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " accepted in time"}, acc, 1);
        if (acc) begin
            if (a[1:0] == 2'b00) begin
                wq.push_back({a, d});
                ref_mem[a] = d;
                pushes++;
            end else begin
                err_m[1] = 1'b1;
            end
        end
        core_write = 1'b0;
        chk({tag, " err_bits"}, err_bits, err_m);
    endtask

    task automatic do_load(input logic [31:0] a, input int exp_lat, input string tag);
        logic [31:0] exp_d;
        bit done;
        int n;
        exp_d = (a[1:0] != 2'b00) ? 32'h0 : ref_rd(a);
        if (a[1:0] != 2'b00) err_m[0] = 1'b1;
        core_write = 1'b0;
        core_read = 1'b1;
        core_addr = a;
        done = 0;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk); #1;
            if (core_rvalid) begin
                done = 1;
            end else begin
                chk({tag, " stall while pending"}, core_stall, 1'b1);
                n++;
                @(posedge clk); #1;
            end
        end
        chk({tag, " completes in time"}, done, 1);
        if (done) begin
            chk({tag, " rdata"}, core_rdata, exp_d);
            chk({tag, " stall released"}, core_stall, 1'b0);
            if (exp_lat >= 0) chk({tag, " stall cycles"}, n, exp_lat);
        end
        @(posedge clk); #1;
        core_read = 1'b0;
        chk({tag, " err_bits"}, err_bits, err_m);
    endtask

    task automatic wait_drained(input string tag);
        int n;
        n = 0;
        @(negedge clk); #1;
        while (drained !== 1'b1 && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        chk({tag, " drained"}, drained, 1'b1);
        chk({tag, " all writes seen"}, wq.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r0;
        int op;
        logic [31:0] a;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst core_rvalid", core_rvalid, 1'b0);
        chk("rst core_rdata", core_rdata, 32'h0);
        chk("rst core_stall", core_stall, 1'b0);
        chk("rst err_bits", err_bits, 2'b00);
        chk("rst drained", drained, 1'b1);
        chk("rst mem outputs", {mem_req, mem_we, mem_addr, mem_wdata}, 66'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Store then immediate load: forwarded with one stall cycle, no memory read
        rdy_mode = 1;
        r0 = rd_cnt;
        do_store(32'h100, 32'hDEADBEEF, "fwd st", n);
        do_load(32'h100, 1, "fwd ld");
        chk("fwd no mem read", rd_cnt, r0);
        wait_drained("fwd");

        // Two stores to the same word: youngest forwarded, memory sees both in order
        r0 = rd_cnt;
        do_store(32'h100, 32'h11, "dup st1", n);
        do_store(32'h100, 32'h22, "dup st2", n);
        do_load(32'h100, -1, "dup ld");
        chk("dup no mem read", rd_cnt, r0);
        wait_drained("dup");
        chk("dup final memory", phys_rd(32'h100), 32'h22);

        // Full buffer: fifth store stalls until one entry retires, then enqueues
        rdy_mode = 0;
        for (int i = 0; i < 4; i++) begin
            do_store(32'h500 + 32'(i * 4), 32'h5000 + 32'(i), "fill st", n);
            chk("fill st no stall", n, 1);
        end
        rdy_mode = 3;
        rdy_delay = 6;
        do_store(32'h510, 32'h5004, "fifth st", n);
        chk("fifth st stalled", 32'(n > 1), 1);
        core_write = 1'b1;
        core_addr = 32'h600;
        core_wdata = 32'h6666;
        @(negedge clk); #1;
        chk("full again after fifth", core_stall, 1'b1);
        core_write = 1'b0;
        @(posedge clk); #1;
        rdy_mode = 1;
        wait_drained("full");

        // Load miss with delayed ready
        phys_mem[32'h200] = 32'hCAFEF00D;
        ref_mem[32'h200] = 32'hCAFEF00D;
        rdy_mode = 3;
        rdy_delay = 3;
        r0 = rd_cnt;
        do_load(32'h200, 5, "miss ld");
        chk("miss one mem read", rd_cnt, r0 + 1);
        chk("miss req cycles", rd_age, 4);
        rdy_mode = 1;

        // Misaligned store and load
        r0 = rd_cnt;
        do_store(32'h102, 32'h12345678, "mis st", n);
        @(negedge clk); #1;
        chk("mis st not enqueued", drained, 1'b1);
        @(posedge clk); #1;
        do_load(32'h203, 1, "mis ld");
        chk("mis ld no mem read", rd_cnt, r0);
        chk("mis err both", err_bits, 2'b11);

        // Asynchronous reset mid-drain
        rdy_mode = 0;
        do_store(32'h300, 32'h11112222, "rst st1", n);
        do_store(32'h304, 32'h33334444, "rst st2", n);
        @(negedge clk); #1;
        chk("pre-reset req", mem_req, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk("async rst mem_req", mem_req, 1'b0);
        chk("async rst drained", drained, 1'b1);
        chk("async rst err_bits", err_bits, 2'b00);
        ref_mem = phys_mem;
        wq.delete();
        pushes = 0;
        wr_done = 0;
        err_m = 2'b00;
        comp_pend = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rdy_mode = 1;
        r0 = rd_cnt;
        do_load(32'h300, 2, "post-rst ld");
        chk("post-rst goes to memory", rd_cnt, r0 + 1);

        // Random traffic against the architectural model
        rdy_mode = 2;
        for (int k = 0; k < 250; k++) begin
            op = int'($urandom_range(0, 99));
            a = 32'h400 + 32'($urandom_range(0, 7)) * 4;
            if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
            if (op < 45) do_store(a, $urandom(), "rnd st", n);
            else if (op < 80) do_load(a, -1, "rnd ld");
            else begin
                @(posedge clk); #1;
            end
        end
        wait_drained("rnd");
        chk("final err_bits", err_bits, err_m);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
